// File: rtl/t2b_decoder_n_if.sv
// Bus bundle for the transition-to-binary decoder: race-logic lanes in,
// per-gamma binary times out.
interface t2b_decoder_n_if #(
  parameter int unsigned NUM_INPUTS = 16,
  parameter int unsigned TIME_WIDTH = 4
);
  logic [NUM_INPUTS-1:0]            inputs;
  logic                             gamma_sync;
  logic [TIME_WIDTH-1:0]            phase;
  logic [NUM_INPUTS*TIME_WIDTH-1:0] time_out;
  logic [NUM_INPUTS-1:0]            spiked;
  logic                             out_valid;

  modport master (
    output inputs, gamma_sync,
    input  phase, time_out, spiked, out_valid
  );

  modport slave (
    input  inputs, gamma_sync,
    output phase, time_out, spiked, out_valid
  );
endinterface

// File: rtl/t2b_decoder_n.sv
// Converts N transition-coded lanes to binary: per gamma cycle, reports the
// phase at which each lane first went high, with a one-cycle valid strobe.
module t2b_decoder_n #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned NUM_INPUTS        = 16,
  parameter int unsigned TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  t2b_decoder_n_if.slave bus
);

  localparam logic [TIME_WIDTH-1:0] LAST_PHASE = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  typedef logic [NUM_INPUTS-1:0][TIME_WIDTH-1:0] times_t;

  logic [TIME_WIDTH-1:0] phase_q;
  logic [NUM_INPUTS-1:0] cap_q;
  logic [NUM_INPUTS-1:0] cap_nxt_c;
  times_t                wt_q;
  times_t                wt_nxt_c;
  times_t                time_q;
  logic [NUM_INPUTS-1:0] spiked_q;
  logic                  out_valid_q;
  logic                  gamma_end_c;

  // First-high capture: only an uncaptured lane latches the current phase.
  always_comb begin
    cap_nxt_c = cap_q;
    wt_nxt_c  = wt_q;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (bus.inputs[i] && !cap_q[i]) begin
        cap_nxt_c[i] = 1'b1;
        wt_nxt_c[i]  = phase_q;
      end
    end
  end

  assign gamma_end_c = (phase_q == LAST_PHASE) && !bus.gamma_sync;

  // gamma_sync wins over end-of-gamma; results load including this edge's captures.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      phase_q     <= '0;
      cap_q       <= '0;
      wt_q        <= '0;
      time_q      <= '0;
      spiked_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.gamma_sync) begin
        phase_q <= '0;
        cap_q   <= '0;
        wt_q    <= '0;
      end else if (gamma_end_c) begin
        time_q      <= wt_nxt_c;
        spiked_q    <= cap_nxt_c;
        out_valid_q <= 1'b1;
        phase_q     <= '0;
        cap_q       <= '0;
        wt_q        <= '0;
      end else begin
        phase_q <= phase_q + TIME_WIDTH'(1);
        cap_q   <= cap_nxt_c;
        wt_q    <= wt_nxt_c;
      end
    end
  end

  assign bus.phase     = phase_q;
  assign bus.time_out  = time_q;
  assign bus.spiked    = spiked_q;
  assign bus.out_valid = out_valid_q;

endmodule
